// File: rtl/flot2fxd_pkg.sv
// Shared constants and types for the float-to-unsigned-fixed converter.
package flot_pkg;
  localparam int IN_D  = 19;
  localparam int MAN_D = 23;
  localparam int EXP_D = 8;
  localparam int BIAS  = (1 << (EXP_D - 1)) - 1;
  localparam int CNT_W = $clog2(MAN_D + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
endpackage

// File: rtl/flot2fxd_if.sv
// Operand/result handshake bundle between a float producer and the converter.
interface flot2fxd_if #(
  parameter int IN_W  = 19,
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   a;
  logic                   out_valid;
  logic                   out_ready;
  logic [IN_W-1:0]        b;
  logic                   zro;
  logic                   ovf;

  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, b, zro, ovf);
  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, b, zro, ovf);
endinterface

// File: rtl/flot2fxd_classify.sv
// Combinational decode of a float operand into shifter load value, shift count
// and overflow flag; out-of-range operands load their final value with count 0.
module flot_classify
  import flot_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int CW    = 5
) (
  input  logic [EXP_W+MAN_W:0] i_a,
  output logic [MAN_W:0]       o_load,
  output logic [CW-1:0]        o_cnt,
  output logic                 o_ovf
);
  localparam logic signed [EXP_W+1:0] BIAS_L = (EXP_W+2)'(bias_of(EXP_W));
  localparam logic signed [EXP_W+1:0] IN_L   = (EXP_W+2)'(IN_W);
  localparam logic signed [EXP_W+1:0] MAN_L  = (EXP_W+2)'(MAN_W);
  localparam logic [MAN_W:0]          SAT    = (MAN_W+1)'((64'd1 << IN_W) - 64'd1);

  logic                    w_s;
  logic [EXP_W-1:0]        w_e;
  logic [MAN_W-1:0]        w_m;
  logic signed [EXP_W+1:0] w_ex;

  assign w_s  = i_a[EXP_W+MAN_W];
  assign w_e  = i_a[EXP_W+MAN_W-1:MAN_W];
  assign w_m  = i_a[MAN_W-1:0];
  assign w_ex = $signed({2'b00, w_e}) - BIAS_L;

  always_comb begin
    o_load = '0;
    o_cnt  = '0;
    o_ovf  = 1'b0;
    if (&w_e) begin
      o_ovf = 1'b1;
      if (w_m == '0 && !w_s) o_load = SAT;
    end else if (w_e == '0 || w_ex < 0) begin
      o_ovf = 1'b0;
    end else if (w_s) begin
      o_ovf = 1'b1;
    end else if (w_ex >= IN_L) begin
      o_ovf  = 1'b1;
      o_load = SAT;
    end else begin
      o_load = {1'b1, w_m};
      o_cnt  = CW'(MAN_L - w_ex);
    end
  end
endmodule

// File: rtl/flot2fxd.sv
// Iterative float -> unsigned integer converter: one right-shift per cycle,
// truncating toward zero, with zero and saturation flags.
module flot2fxd
  import flot_pkg::*;
#(
  parameter int IN_W  = IN_D,
  parameter int MAN_W = MAN_D,
  parameter int EXP_W = EXP_D
) (
  input  logic        clk,
  input  logic        rst,
  flot2fxd_if.slave   io
);
  localparam int CW = $clog2(MAN_W + 1);

  state_t          r_state, w_nxt;
  logic [MAN_W:0]  r_sh;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_p;
  logic [IN_W-1:0] r_b;
  logic            r_zro;
  logic            r_ovf;

  logic [MAN_W:0]  w_load;
  logic [CW-1:0]   w_cnt;
  logic            w_ovf;

  flot_classify #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W), .CW(CW)) u_cls (
    .i_a    (io.a),
    .o_load (w_load),
    .o_cnt  (w_cnt),
    .o_ovf  (w_ovf)
  );

  assign io.in_ready  = (r_state == IDLE);
  assign io.out_valid = (r_state == DONE);
  assign io.b         = r_b;
  assign io.zro       = r_zro;
  assign io.ovf       = r_ovf;

  // Every operand passes through SHIFT; special cases arrive with count 0,
  // giving them a single-cycle latency like a fully aligned mantissa.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (io.in_valid)     w_nxt = SHIFT;
      SHIFT:   if (r_cnt == '0)     w_nxt = DONE;
      DONE:    if (io.out_ready)    w_nxt = IDLE;
      default:                      w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_ovf_p <= 1'b0;
      r_b     <= '0;
      r_zro   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (io.in_valid) begin
          r_sh    <= w_load;
          r_cnt   <= w_cnt;
          r_ovf_p <= w_ovf;
        end
        SHIFT: if (r_cnt != '0) begin
          r_sh  <= r_sh >> 1;
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_b   <= r_sh[IN_W-1:0];
          r_zro <= (r_sh[IN_W-1:0] == '0);
          r_ovf <= r_ovf_p;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flot2fxd.sv
// Table-driven bench with an expected-result queue plus backpressure and reset corner cases.
module tb_flot2fxd;
  typedef struct {
    logic [31:0] a;
    int          b;
    int          zro;
    int          ovf;
    int          lat;
  } vec_t;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;
  vec_t q[$];
  vec_t tbl[16];

  flot2fxd_if #(.IN_W(19), .MAN_W(23), .EXP_W(8)) io ();

  flot2fxd #(.IN_W(19), .MAN_W(23), .EXP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand, wait for the result, pop the expectation and compare.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    bit   seen;
    chk("in_ready_before", int'(io.in_ready), 1);
    io.in_valid = 1'b1;
    io.a        = v.a;
    tick();
    io.in_valid = 1'b0;
    q.push_back(v);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      lat++;
      if (io.out_valid) seen = 1'b1;
    end
    chk("out_valid_seen", int'(seen), 1);
    if (q.size() == 0) begin
      chk("queue_nonempty", 0, 1);
    end else begin
      e = q.pop_front();
      chk($sformatf("b_%h", e.a),   int'(io.b),   e.b);
      chk($sformatf("zro_%h", e.a), int'(io.zro), e.zro);
      chk($sformatf("ovf_%h", e.a), int'(io.ovf), e.ovf);
      chk($sformatf("lat_%h", e.a), lat,          e.lat);
    end
    if (io.out_ready) tick();
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{32'h44800000,   1024, 0, 0, 14};
    tbl[1]  = '{32'h47800000,  65536, 0, 0,  8};
    tbl[2]  = '{32'h47F12000, 123456, 0, 0,  8};
    tbl[3]  = '{32'h3F800000,      1, 0, 0, 24};
    tbl[4]  = '{32'h40700000,      3, 0, 0, 23};
    tbl[5]  = '{32'h3F000000,      0, 1, 0,  1};
    tbl[6]  = '{32'h49000000, 524287, 0, 1,  1};
    tbl[7]  = '{32'h7F800000, 524287, 0, 1,  1};
    tbl[8]  = '{32'h7FC00000,      0, 1, 1,  1};
    tbl[9]  = '{32'hC0A00000,      0, 1, 1,  1};
    tbl[10] = '{32'h80000000,      0, 1, 0,  1};
    tbl[11] = '{32'hFF800000,      0, 1, 1,  1};
    tbl[12] = '{32'h48800000, 262144, 0, 0,  6};
    tbl[13] = '{32'h48FFFFFF, 524287, 0, 0,  6};
    tbl[14] = '{32'hBF000000,      0, 1, 0,  1};
    tbl[15] = '{32'h00400000,      0, 1, 0,  1};

    rst = 1'b1;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  int'(io.in_ready),  1);
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_b",         int'(io.b),         0);
    chk("rst_zro",       int'(io.zro),       0);
    chk("rst_ovf",       int'(io.ovf),       0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Backpressure: result held, new operand ignored while DONE.
    io.out_ready = 1'b0;
    run_vec(tbl[0]);
    for (int c = 0; c < 10; c++) begin
      io.in_valid = 1'b1;
      io.a        = 32'h3F800000;
      tick();
      chk("bp_out_valid", int'(io.out_valid), 1);
      chk("bp_in_ready",  int'(io.in_ready),  0);
      chk("bp_b",         int'(io.b),         1024);
      chk("bp_ovf",       int'(io.ovf),       0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", int'(io.out_valid), 0);
    chk("bp_release_in_ready",  int'(io.in_ready),  1);
    run_vec(tbl[1]);

    // Reset in the middle of a long shift discards the partial result.
    io.in_valid = 1'b1;
    io.a        = 32'h3F800000;
    tick();
    io.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("mid_out_valid", int'(io.out_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", int'(io.out_valid), 0);
    chk("mrst_in_ready",  int'(io.in_ready),  1);
    chk("mrst_b",         int'(io.b),         0);
    chk("mrst_zro",       int'(io.zro),       0);
    v = tbl[2];
    run_vec(v);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
